// File: rtl/coloring_stream_checker.sv
// Streaming graph-colouring verifier: latches a colour vector on start, then checks
// one edge per cycle for monochromatic endpoints, counting conflicts and range errors.
//   state  | meaning
//   IDLE   | waiting for start, results cleared
//   RUN    | accepting edge beats
//   FINISH | one cycle to fold count and range error into valid_coloring
//   DONE   | results held, start begins a fresh run
module coloring_stream_checker #(
    parameter int NUM_V      = 6,
    parameter int COLOR_W    = 2,
    parameter int NUM_COLORS = 4,
    parameter int CNT_W      = 8,
    localparam int VID_W     = (NUM_V > 2) ? $clog2(NUM_V) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_V*COLOR_W-1:0] colors,
    input  logic                     edge_valid,
    output logic                     edge_ready,
    input  logic [VID_W-1:0]         edge_u,
    input  logic [VID_W-1:0]         edge_v,
    input  logic                     edge_last,
    output logic                     busy,
    output logic                     done,
    output logic                     valid_coloring,
    output logic [CNT_W-1:0]         conflict_count,
    output logic [VID_W-1:0]         first_u,
    output logic [VID_W-1:0]         first_v,
    output logic                     range_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [NUM_V*COLOR_W-1:0] r_colors;
    logic [CNT_W-1:0]         r_count;
    logic [VID_W-1:0]         r_first_u, r_first_v;
    logic                     r_seen, r_range_err, r_valid;
    logic                     w_start_acc, w_accept, w_idx_bad, w_col_bad, w_same;

    // Loop-based lookup keeps out-of-range indices from slicing past the vector.
    function automatic logic [COLOR_W-1:0] color_of(input logic [NUM_V*COLOR_W-1:0] cv,
                                                    input logic [VID_W-1:0] idx);
        color_of = '0;
        for (int k = 0; k < NUM_V; k++)
            if (int'(idx) == k) color_of = cv[k*COLOR_W +: COLOR_W];
    endfunction

    always_comb begin
        w_col_bad = 1'b0;
        for (int k = 0; k < NUM_V; k++)
            if (int'(colors[k*COLOR_W +: COLOR_W]) >= NUM_COLORS) w_col_bad = 1'b1;
    end

    assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept    = edge_valid && (r_state == S_RUN);
    assign w_idx_bad   = (int'(edge_u) >= NUM_V) || (int'(edge_v) >= NUM_V);
    assign w_same      = (color_of(r_colors, edge_u) == color_of(r_colors, edge_v));

    always_comb begin
        w_next     = r_state;
        edge_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                edge_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept && edge_last) w_next = S_FINISH;
            end
            S_FINISH: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_colors    <= '0;
            r_count     <= '0;
            r_first_u   <= '0;
            r_first_v   <= '0;
            r_seen      <= 1'b0;
            r_range_err <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_acc) begin
                r_colors    <= colors;
                r_count     <= '0;
                r_first_u   <= '0;
                r_first_v   <= '0;
                r_seen      <= 1'b0;
                r_range_err <= w_col_bad;
                r_valid     <= 1'b0;
            end else if (w_accept) begin
                // A bad index flags the run but the edge is never compared.
                if (w_idx_bad) begin
                    r_range_err <= 1'b1;
                end else if (w_same) begin
                    if (r_count != '1) r_count <= r_count + CNT_W'(1);
                    if (!r_seen) begin
                        r_seen    <= 1'b1;
                        r_first_u <= edge_u;
                        r_first_v <= edge_v;
                    end
                end
            end else if (r_state == S_FINISH) begin
                r_valid <= (r_count == '0) && !r_range_err;
            end
        end
    end

    assign valid_coloring = r_valid;
    assign conflict_count = r_count;
    assign first_u        = r_first_u;
    assign first_v        = r_first_v;
    assign range_err      = r_range_err;

endmodule

// File: tb/tb_coloring_stream_checker.sv
// Directed bench for coloring_stream_checker: two instances (default and 3-colour,
// 2-bit-counter) share stimulus; expected results are queued and checked on done.
module tb_coloring_stream_checker;

    logic        clk = 1'b0;
    logic        rst, start, edge_valid, edge_last;
    logic [11:0] colors;
    logic [2:0]  edge_u, edge_v;

    logic       a_ready, a_busy, a_done, a_valid, a_rerr;
    logic [7:0] a_count;
    logic [2:0] a_fu, a_fv;
    logic       b_ready, b_busy, b_done, b_valid, b_rerr;
    logic [1:0] b_count;
    logic [2:0] b_fu, b_fv;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic valid;
        int   count;
        int   fu;
        int   fv;
        logic rerr;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    int   eu[$];
    int   ev[$];

    always #5 clk = ~clk;

    coloring_stream_checker dut_a (
        .clk(clk), .rst(rst), .start(start), .colors(colors),
        .edge_valid(edge_valid), .edge_ready(a_ready), .edge_u(edge_u), .edge_v(edge_v),
        .edge_last(edge_last), .busy(a_busy), .done(a_done), .valid_coloring(a_valid),
        .conflict_count(a_count), .first_u(a_fu), .first_v(a_fv), .range_err(a_rerr)
    );

    coloring_stream_checker #(.NUM_COLORS(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .colors(colors),
        .edge_valid(edge_valid), .edge_ready(b_ready), .edge_u(edge_u), .edge_v(edge_v),
        .edge_last(edge_last), .busy(b_busy), .done(b_done), .valid_coloring(b_valid),
        .conflict_count(b_count), .first_u(b_fu), .first_v(b_fv), .range_err(b_rerr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [11:0] c, input int ncol, input int cmax);
        res_t r;
        bit   seen;
        int   cu, cv;
        r.valid = 1'b0; r.count = 0; r.fu = 0; r.fv = 0; r.rerr = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++)
            if (int'(c[k*2 +: 2]) >= ncol) r.rerr = 1'b1;
        for (int i = 0; i < eu.size(); i++) begin
            if (eu[i] >= 6 || ev[i] >= 6) begin
                r.rerr = 1'b1;
            end else begin
                cu = int'(c[eu[i]*2 +: 2]);
                cv = int'(c[ev[i]*2 +: 2]);
                if (cu == cv) begin
                    if (r.count < cmax) r.count++;
                    if (!seen) begin
                        seen = 1'b1; r.fu = eu[i]; r.fv = ev[i];
                    end
                end
            end
        end
        r.valid = (r.count == 0) && !r.rerr;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, a_ready, 0);
        check({tag, "_busy"},  a_busy, 0);
        check({tag, "_done"},  a_done, 0);
        check({tag, "_valid"}, a_valid, 0);
        check({tag, "_count"}, a_count, 0);
        check({tag, "_fu"},    a_fu, 0);
        check({tag, "_fv"},    a_fv, 0);
        check({tag, "_rerr"},  a_rerr, 0);
        check({tag, "_b_cnt"}, b_count, 0);
    endtask

    task automatic compare_results(input string tag);
        res_t ea, eb;
        check({tag, "_qa_nonempty"}, (qa.size() > 0), 1);
        check({tag, "_qb_nonempty"}, (qb.size() > 0), 1);
        if (qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            check({tag, "_a_valid"}, a_valid, ea.valid);
            check({tag, "_a_count"}, a_count, ea.count);
            check({tag, "_a_fu"},    a_fu, ea.fu);
            check({tag, "_a_fv"},    a_fv, ea.fv);
            check({tag, "_a_rerr"},  a_rerr, ea.rerr);
            check({tag, "_b_done"},  b_done, 1);
            check({tag, "_b_valid"}, b_valid, eb.valid);
            check({tag, "_b_count"}, b_count, eb.count);
            check({tag, "_b_fu"},    b_fu, eb.fu);
            check({tag, "_b_fv"},    b_fv, eb.fv);
            check({tag, "_b_rerr"},  b_rerr, eb.rerr);
        end
    endtask

    // Runs the current edge list; gaps insert idle cycles carrying noise and start pulses.
    task automatic run_graph(input string tag, input logic [11:0] c, input bit gaps);
        int k;
        @(negedge clk);
        start  = 1'b1;
        colors = c;
        @(negedge clk);
        start  = 1'b0;
        colors = ~c;
        check({tag, "_ready_t1"}, a_ready, 1);
        check({tag, "_busy_t1"},  a_busy, 1);
        check({tag, "_done_t1"},  a_done, 0);
        check({tag, "_count_t1"}, a_count, 0);
        check({tag, "_fu_t1"},    a_fu, 0);
        check({tag, "_valid_t1"}, a_valid, 0);
        for (int i = 0; i < eu.size(); i++) begin
            if (gaps) begin
                edge_valid = 1'b0;
                edge_last  = 1'b1;
                edge_u     = 3'd1;
                edge_v     = 3'd1;
                start      = 1'b1;
                colors     = 12'h000;
                @(negedge clk);
                start = 1'b0;
            end
            edge_valid = 1'b1;
            edge_u     = 3'(eu[i]);
            edge_v     = 3'(ev[i]);
            edge_last  = (i == eu.size() - 1);
            @(negedge clk);
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        qa.push_back(model(c, 4, 255));
        qb.push_back(model(c, 3, 3));
        check({tag, "_fin_done"},  a_done, 0);
        check({tag, "_fin_busy"},  a_busy, 1);
        check({tag, "_fin_ready"}, a_ready, 0);
        k = 0;
        while (!a_done && k < 5) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_latency"}, k, 1);
        check({tag, "_done_ready"}, a_ready, 0);
        compare_results(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b1; colors = 12'h0;
        edge_valid = 1'b0; edge_last = 1'b0; edge_u = 3'd0; edge_v = 3'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_with_start");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_after_rst");

        // Valid colouring {0,1,0,2,0,3}; colour 3 is a range error for the 3-colour instance.
        eu = '{0, 1, 1, 2, 3}; ev = '{1, 2, 5, 3, 4};
        run_graph("valid", {2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0}, 1'b0);

        // Conflicts {0,1,1,1,1,1}, started from DONE.
        run_graph("conflict", {2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0}, 1'b0);

        // Restart from DONE must clear; out-of-range edge (2,7) and a self-loop.
        eu = '{0, 2, 3}; ev = '{1, 7, 3};
        run_graph("idx_range", {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0}, 1'b0);

        // Saturation with gaps, start pulses and a self-loop.
        eu = '{0, 1, 4, 2, 3, 0}; ev = '{1, 2, 4, 3, 5, 5};
        run_graph("saturate", {2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, 1'b1);

        // Reset mid-stream after two accepted conflicting edges.
        @(negedge clk);
        start = 1'b1; colors = 12'hFFF;
        @(negedge clk);
        start = 1'b0;
        edge_valid = 1'b1; edge_u = 3'd0; edge_v = 3'd1; edge_last = 1'b0;
        @(negedge clk);
        edge_u = 3'd1; edge_v = 3'd2;
        @(negedge clk);
        check("pre_reset_count", a_count, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        edge_last = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle_ignores_edges");
        edge_valid = 1'b0; edge_last = 1'b0;

        // Fresh graph after reset: proper 3-colouring of a 6-cycle.
        eu = '{0, 1, 2, 3, 4, 5}; ev = '{1, 2, 3, 4, 5, 0};
        run_graph("after_rst", {2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2}, 1'b0);

        check("queues_drained", qa.size() + qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/coloring_stream_checker.md
# coloring_stream_checker

Parametrised, sequential graph-colouring verifier. A colour assignment for `NUM_V` vertices is latched in parallel on `start`. Edges are then streamed one per cycle over a valid/ready handshake, and the block reports whether any edge joins two vertices of the same colour. It generalises the fixed 6-vertex, 2-bit, hard-wired-edge combinational checker in the colouring test flow to arbitrary graph size, colour width and run-time edge lists. It adds conflict counting, first-conflict capture and range checking.

## Interface
- `NUM_V`, 6, number of vertices (≥2)
- `COLOR_W`, 2, bits per vertex colour
- `NUM_COLORS`, 4, legal colours are 0..NUM_COLORS-1 (≤ 2^COLOR_W)
- `CNT_W`, 8, width of conflict counter (saturating)
- `VID_W`, derived = max(1, clog2(NUM_V)), vertex index width
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a check; honoured only in IDLE or DONE
- `colors`  in  NUM_V*COLOR_W  vertex k colour at bits [k*COLOR_W +: COLOR_W]; sampled on accepted `start`
- `edge_valid`  in  1  edge beat present
- `edge_ready`  out  1  block accepts edge beat
- `edge_u`, `edge_v`  in  VID_W  edge endpoints
- `edge_last`  in  1  final edge of this graph
- `busy`  out  1  high in RUN and FINISH
- `done`  out  1  high in DONE; results valid
- `valid_coloring`  out  1  no conflicts and no range errors
- `conflict_count`  out  CNT_W  monochromatic edges seen, saturates at all-ones
- `first_u`, `first_v`  out  VID_W  endpoints of first conflicting edge (0 if none)
- `range_err`  out  1  a vertex index ≥ NUM_V, or a colour ≥ NUM_COLORS

## Operation
- States: IDLE, RUN, FINISH, DONE.
- **IDLE → RUN** on `start`:
  - latch `colors`;
  - clear count, first_*, and internal first-seen flag;
  - set `range_err` if any latched colour ≥ NUM_COLORS.
- **RUN:**
  - `edge_ready`=1; a beat is accepted when `edge_valid & edge_ready`.
  - Per accepted beat, if either index ≥ NUM_V:
    - set `range_err`;
    - do not compare the edge.
  - Otherwise, if colour(u) == colour(v), including self-loop u==v:
    - increment `conflict_count` (saturating);
    - if this is the first conflict, capture `first_u`/`first_v`.
  - Accepted beat with `edge_last`=1 → FINISH.
  - `start` is ignored in RUN.
- **FINISH:** one cycle; `edge_ready`=0; compute `valid_coloring` = (count==0) & ~range_err. Then → DONE.
- **DONE:**
  - `done`=1; results held stable.
  - `edge_ready`=0; edges are ignored.
  - `start` → RUN with a fresh latch and cleared results (same as from IDLE).
- **Reset** (in any state, including mid-stream): → IDLE. Outputs after reset:
  - `edge_ready`=0, `busy`=0, `done`=0, `valid_coloring`=0;
  - `conflict_count`=0, `first_u`=0, `first_v`=0, `range_err`=0.
- Empty graph is not representable: at least one edge beat, carrying `edge_last`, is required.

## Timing
- `start` sampled at edge T. RUN is entered at T+1, and `edge_ready`=1 from T+1.
- Throughput: one edge per cycle, with no bubbles while `edge_valid` is held.
- Count and first_* update one cycle after the accepting edge.
- Last beat accepted at edge L:
  - FINISH during L+1;
  - `done`=1 and results valid from L+2;
  - latency from last edge to done is 2 cycles.
- `colors` may change freely after the `start` cycle, with no effect on the run in progress.
- `edge_valid` low in RUN: the FSM holds and the count is unchanged.
- Simultaneous `rst` and `start`: reset wins.

## Test plan
- **Valid colouring.**
  - NUM_V=6, colors={v0..v5}={0,1,0,2,0,3}; edges (0,1),(1,2),(1,5),(2,3),(3,4), last on (3,4).
  - Required: `done` 2 cycles after last, `valid_coloring`=1, count=0, range_err=0.
- **Conflicts.**
  - Same edges, colors={0,1,1,1,1,1}.
  - Required: count=4 (edges (1,2),(1,5),(2,3),(3,4)), `first_u`=1, `first_v`=2, `valid_coloring`=0.
- **Range errors.**
  - Colour 3 with NUM_COLORS=3: `range_err`=1, `valid_coloring`=0 even with zero conflicts.
  - Edge (2,7) with NUM_V=6: `range_err`=1, and that edge is not counted.
- **Saturation, self-loop and back-pressure.**
  - CNT_W=2, 6 conflicting edges including self-loop (4,4), with `edge_valid` gapped: `conflict_count`=3 (saturated).
  - Gaps cause no spurious counts.
  - `start` pulses during RUN are ignored.
- **Reset and restart.**
  - Assert `rst` after 2 accepted edges: next cycle all outputs are at reset values and the state is IDLE.
  - A new `start` then runs a fresh graph that reports correctly.
  - `start` from DONE clears the previous results at T+1.
